// File: rtl/cpu_alu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_alu_pkg
// Shared definitions for the sequential 6502-family ALU:
//   - op_e     : 4-bit operation codes presented on the ALU op port
//   - FLAG_*   : bit positions inside the 8-bit processor status byte
//   - state_e  : control FSM states (binary ops never leave IDLE)
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_alu_pkg;

    typedef enum logic [3:0] {
        OP_ORA = 4'h0,
        OP_AND = 4'h1,
        OP_EOR = 4'h2,
        OP_ADC = 4'h3,
        OP_STA = 4'h4,
        OP_LDA = 4'h5,
        OP_CMP = 4'h6,
        OP_SBC = 4'h7,
        OP_ASL = 4'h8,
        OP_ROL = 4'h9,
        OP_LSR = 4'hA,
        OP_ROR = 4'hB,
        OP_BIT = 4'hC,
        OP_INC = 4'hD,
        OP_DEC = 4'hE,
        OP_NOP = 4'hF
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DEC  = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_alu_seq_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// Combinational single-nibble decimal add/subtract with decimal adjust.
// Ports:
//   a4   in  4  minuend / addend digit
//   b4   in  4  subtrahend / addend digit
//   cin  in  1  carry in (for subtract: 1 = no borrow)
//   sub  in  1  0 = add, 1 = subtract
//   d4   out 4  adjusted result digit (mod 16 for non-BCD inputs)
//   cout out 1  carry out (for subtract: 1 = no borrow)
// -----------------------------------------------------------------------------
module bcd_digit (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] d4,
    output logic       cout
);

    logic [4:0] w_raw;
    logic [4:0] w_adj;

    always_comb begin
        w_raw = '0;
        w_adj = '0;
        cout  = 1'b0;
        if (!sub) begin
            w_raw = {1'b0, a4} + {1'b0, b4} + {4'b0, cin};
            if (w_raw > 5'd9) begin
                w_adj = w_raw + 5'd6;
                cout  = 1'b1;
            end else begin
                w_adj = w_raw;
                cout  = 1'b0;
            end
        end else begin
            // Bit 4 of the 5-bit difference is the borrow (result went negative).
            w_raw = {1'b0, a4} - {1'b0, b4} - {4'b0, ~cin};
            if (w_raw[4]) begin
                w_adj = w_raw - 5'd6;
                cout  = 1'b0;
            end else begin
                w_adj = w_raw;
                cout  = 1'b1;
            end
        end
        d4 = w_adj[3:0];
    end

endmodule

// File: rtl/cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// cpu_alu_seq
// Registered 6502-family ALU with a valid/ready handshake. Binary ops complete
// in one cycle at full throughput; decimal ADC/SBC (D flag set, DECIMAL_EN=1)
// are processed one BCD digit per cycle, LSB digit first, over WIDTH/4 cycles.
// Ports:
//   clock      in   1      rising-edge clock
//   reset_n    in   1      synchronous active-low reset
//   in_valid   in   1      op/a/b/p_in valid
//   in_ready   out  1      ALU idle, can accept this cycle
//   op         in   4      operation code (cpu_alu_pkg::op_e)
//   a          in   WIDTH  accumulator operand
//   b          in   WIDTH  memory/immediate operand
//   p_in       in   8      status in (C Z I D B - V N)
//   out_valid  out  1      one-cycle pulse, res/p_out valid
//   res        out  WIDTH  result, held until the next out_valid
//   p_out      out  8      status out, untouched bits copied from p_in
// -----------------------------------------------------------------------------
module cpu_alu_seq
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DECIMAL_EN = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       p_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic [7:0]       p_out
);

    localparam int             NDIG   = WIDTH / 4;
    localparam int             KW     = $clog2(NDIG) + 1;
    localparam logic [KW-1:0]  K_LAST = KW'(NDIG - 1);

    state_e           r_state;
    logic [KW-1:0]    r_k;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic [7:0]       r_p_out;

    // Decimal operand/result shifters: the low nibble is always the current digit.
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic             r_sub;
    logic             r_carry;
    logic             r_v;
    logic [7:0]       r_p;

    op_e              w_op;
    logic             w_cin;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_cmp;
    logic [WIDTH-1:0] w_res;
    logic [7:0]       w_p;
    logic             w_setnz;
    logic             w_dec_start;
    logic [3:0]       w_d4;
    logic             w_cout;
    logic [WIDTH-1:0] w_final;
    logic [7:0]       w_dec_p;

    assign w_op     = op_e'(op);
    assign w_cin    = p_in[FLAG_C];
    assign in_ready = (r_state == ST_IDLE);

    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign p_out     = r_p_out;

    assign w_add = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, w_cin};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, w_cin};
    assign w_cmp = {1'b0, a} - {1'b0, b};

    assign w_dec_start = (DECIMAL_EN != 0) && p_in[FLAG_D] &&
                         ((w_op == OP_ADC) || (w_op == OP_SBC));

    // Single-cycle binary datapath; also supplies V for decimal ops, which is
    // defined on the binary sum of the original operands.
    always_comb begin
        w_res   = a;
        w_p     = p_in;
        w_setnz = 1'b0;
        case (w_op)
            OP_ORA: begin w_res = a | b; w_setnz = 1'b1; end
            OP_AND: begin w_res = a & b; w_setnz = 1'b1; end
            OP_EOR: begin w_res = a ^ b; w_setnz = 1'b1; end
            OP_LDA: begin w_res = b;     w_setnz = 1'b1; end
            OP_STA: w_res = b;
            OP_ADC: begin
                w_res         = w_add[WIDTH-1:0];
                w_p[FLAG_C]   = w_add[WIDTH];
                w_p[FLAG_V]   = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ w_add[WIDTH-1]);
                w_setnz       = 1'b1;
            end
            OP_SBC: begin
                w_res         = w_sub[WIDTH-1:0];
                w_p[FLAG_C]   = w_sub[WIDTH];
                w_p[FLAG_V]   = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ w_sub[WIDTH-1]);
                w_setnz       = 1'b1;
            end
            OP_CMP: begin
                // No borrow out of a-b means a >= b unsigned.
                w_res         = a;
                w_p[FLAG_C]   = ~w_cmp[WIDTH];
                w_p[FLAG_N]   = w_cmp[WIDTH-1];
                w_p[FLAG_Z]   = (w_cmp[WIDTH-1:0] == '0);
            end
            OP_ASL: begin
                w_res         = {b[WIDTH-2:0], 1'b0};
                w_p[FLAG_C]   = b[WIDTH-1];
                w_setnz       = 1'b1;
            end
            OP_ROL: begin
                w_res         = {b[WIDTH-2:0], w_cin};
                w_p[FLAG_C]   = b[WIDTH-1];
                w_setnz       = 1'b1;
            end
            OP_LSR: begin
                w_res         = {1'b0, b[WIDTH-1:1]};
                w_p[FLAG_C]   = b[0];
                w_setnz       = 1'b1;
            end
            OP_ROR: begin
                w_res         = {w_cin, b[WIDTH-1:1]};
                w_p[FLAG_C]   = b[0];
                w_setnz       = 1'b1;
            end
            OP_BIT: begin
                w_res         = a;
                w_p[FLAG_Z]   = ((a & b) == '0);
                w_p[FLAG_N]   = b[WIDTH-1];
                w_p[FLAG_V]   = b[WIDTH-2];
            end
            OP_INC: begin w_res = b + 1'b1; w_setnz = 1'b1; end
            OP_DEC: begin w_res = b - 1'b1; w_setnz = 1'b1; end
            default: begin end
        endcase
        if (w_setnz) begin
            w_p[FLAG_N] = w_res[WIDTH-1];
            w_p[FLAG_Z] = (w_res == '0);
        end
    end

    bcd_digit u_bcd_digit (
        .a4   (r_a_sh[3:0]),
        .b4   (r_b_sh[3:0]),
        .cin  (r_carry),
        .sub  (r_sub),
        .d4   (w_d4),
        .cout (w_cout)
    );

    // The last digit enters at the top as the accumulator shifts right, so
    // after WIDTH/4 digits every nibble sits in its own position.
    assign w_final = {w_d4, r_acc[WIDTH-1:4]};

    always_comb begin
        w_dec_p         = r_p;
        w_dec_p[FLAG_C] = w_cout;
        w_dec_p[FLAG_Z] = (w_final == '0);
        w_dec_p[FLAG_N] = w_final[WIDTH-1];
        w_dec_p[FLAG_V] = r_v;
    end

    // Decimal operand latch and digit shifter (data only, no reset needed).
    always_ff @(posedge clock) begin
        if (in_valid && (r_state == ST_IDLE)) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_sub   <= (w_op == OP_SBC);
            r_p     <= p_in;
            r_v     <= w_p[FLAG_V];
            r_carry <= w_cin;
        end else if (r_state == ST_DEC) begin
            r_a_sh  <= r_a_sh >> 4;
            r_b_sh  <= r_b_sh >> 4;
            r_carry <= w_cout;
            r_acc   <= w_final;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_p_out     <= 8'h00;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_dec_start) begin
                            r_state <= ST_DEC;
                            r_k     <= '0;
                        end else begin
                            r_res       <= w_res;
                            r_p_out     <= w_p;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_DEC: begin
                    if (r_k == K_LAST) begin
                        r_state     <= ST_IDLE;
                        r_k         <= '0;
                        r_res       <= w_final;
                        r_p_out     <= w_dec_p;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_alu_seq
// Scoreboard bench for cpu_alu_seq: an 8-bit and a 16-bit instance. The
// stimulus process pushes model results into per-instance queues; monitors pop
// and compare whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_cpu_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        v8, rdy8, ov8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, p8, res8, po8;

    logic        v16, rdy16, ov16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, res16;
    logic [7:0]  p16, po16;

    cpu_alu_seq #(.WIDTH(8), .DECIMAL_EN(1)) dut8 (
        .clock(clk), .reset_n(rst_n), .in_valid(v8), .in_ready(rdy8), .op(op8),
        .a(a8), .b(b8), .p_in(p8), .out_valid(ov8), .res(res8), .p_out(po8)
    );

    cpu_alu_seq #(.WIDTH(16), .DECIMAL_EN(1)) dut16 (
        .clock(clk), .reset_n(rst_n), .in_valid(v16), .in_ready(rdy16), .op(op16),
        .a(a16), .b(b16), .p_in(p16), .out_valid(ov16), .res(res16), .p_out(po16)
    );

    typedef struct {
        int         res;
        logic [7:0] p;
        int         due;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rdy_at8 = 0;
    int   rdy_at16 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit bt(input int x, input int i);
        return ((x >> i) & 1) != 0;
    endfunction

    // Reference model: ALU rules applied with plain integer arithmetic.
    function automatic void model(input int w, input int opc, input int a, input int b,
                                  input logic [7:0] p, output int r,
                                  output logic [7:0] po, output bit dec);
        int  mask, c, s, cc, ad, bd, dr;
        bit  nz;
        mask = (1 << w) - 1;
        c    = p[0] ? 1 : 0;
        po   = p;
        nz   = 1'b0;
        r    = a;
        dec  = p[3] && (opc == 3 || opc == 7);
        case (opc)
            0:  begin r = a | b; nz = 1'b1; end
            1:  begin r = a & b; nz = 1'b1; end
            2:  begin r = a ^ b; nz = 1'b1; end
            3:  begin
                s = a + b + c; r = s & mask; po[0] = (s > mask);
                po[6] = bt((~(a ^ b)) & (a ^ r), w - 1); nz = 1'b1;
            end
            4:  r = b;
            5:  begin r = b; nz = 1'b1; end
            6:  begin
                r = a; po[0] = (a >= b);
                po[7] = bt((a - b) & mask, w - 1); po[1] = (((a - b) & mask) == 0);
            end
            7:  begin
                s = a + ((~b) & mask) + c; r = s & mask; po[0] = (s > mask);
                po[6] = bt((a ^ b) & (a ^ r), w - 1); nz = 1'b1;
            end
            8:  begin po[0] = bt(b, w - 1); r = (b << 1) & mask; nz = 1'b1; end
            9:  begin po[0] = bt(b, w - 1); r = ((b << 1) | c) & mask; nz = 1'b1; end
            10: begin po[0] = bt(b, 0); r = b >> 1; nz = 1'b1; end
            11: begin po[0] = bt(b, 0); r = (b >> 1) | (c << (w - 1)); nz = 1'b1; end
            12: begin
                r = a; po[1] = ((a & b) == 0); po[7] = bt(b, w - 1); po[6] = bt(b, w - 2);
            end
            13: begin r = (b + 1) & mask; nz = 1'b1; end
            14: begin r = (b - 1) & mask; nz = 1'b1; end
            default: r = a;
        endcase
        if (dec) begin
            cc = c;
            dr = 0;
            for (int k = 0; k < w / 4; k++) begin
                ad = (a >> (4 * k)) & 15;
                bd = (b >> (4 * k)) & 15;
                if (opc == 3) begin
                    s = ad + bd + cc;
                    if (s > 9) begin s = s + 6; cc = 1; end else cc = 0;
                end else begin
                    s = ad - bd - (1 - cc);
                    if (s < 0) begin s = s - 6; cc = 0; end else cc = 1;
                end
                dr = dr | ((s & 15) << (4 * k));
            end
            r     = dr;
            po[0] = (cc != 0);
        end
        if (nz) begin
            po[7] = bt(r, w - 1);
            po[1] = (r == 0);
        end
    endfunction

    task automatic send(input bit wide, input int opc, input int a_i, input int b_i,
                        input logic [7:0] p_i);
        int         n, w, r, lat;
        logic [7:0] pe;
        bit         dec;
        exp_t       e;
        w = wide ? 16 : 8;
        @(negedge clk);
        if (wide) begin
            v16 = 1'b1; op16 = opc[3:0]; a16 = a_i[15:0]; b16 = b_i[15:0]; p16 = p_i;
        end else begin
            v8 = 1'b1; op8 = opc[3:0]; a8 = a_i[7:0]; b8 = b_i[7:0]; p8 = p_i;
        end
        n = 0;
        while (!(wide ? rdy16 : rdy8)) begin
            chk(wide ? "in_ready16_busy" : "in_ready8_busy", 0,
                (cyc >= (wide ? rdy_at16 : rdy_at8)) ? 1 : 0);
            n++;
            if (n > 40) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: in_ready stuck 0, expected 1 within 40 cycles");
                v8 = 1'b0;
                v16 = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk(wide ? "in_ready16" : "in_ready8", 1,
            (cyc >= (wide ? rdy_at16 : rdy_at8)) ? 1 : 0);
        model(w, opc, a_i, b_i, p_i, r, pe, dec);
        lat   = dec ? (w / 4) : 0;
        e.res = r;
        e.p   = pe;
        e.due = cyc + 1 + lat;
        if (wide) begin q16.push_back(e); rdy_at16 = cyc + 1 + lat; end
        else      begin q8.push_back(e);  rdy_at8  = cyc + 1 + lat; end
        @(posedge clk);
        #1;
        if (wide) v16 = 1'b0; else v8 = 1'b0;
    endtask

    // Monitors
    exp_t m8, m16;

    always @(negedge clk) begin
        if (q8.size() > 0 && q8[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_out8: out_valid 0, expected 1 at cycle %0d", q8[0].due);
            void'(q8.pop_front());
        end
        if (ov8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out8: out_valid 1, expected 0 (cycle %0d)", cyc);
            end else begin
                m8 = q8.pop_front();
                chk("res8", int'(res8), m8.res);
                chk("p_out8", int'(po8), int'(m8.p));
                chk("latency8", cyc, m8.due);
            end
        end
    end

    always @(negedge clk) begin
        if (q16.size() > 0 && q16[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_out16: out_valid 0, expected 1 at cycle %0d", q16[0].due);
            void'(q16.pop_front());
        end
        if (ov16) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out16: out_valid 1, expected 0 (cycle %0d)", cyc);
            end else begin
                m16 = q16.pop_front();
                chk("res16", int'(res16), m16.res);
                chk("p_out16", int'(po16), int'(m16.p));
                chk("latency16", cyc, m16.due);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; p8 = '0;
        v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; p16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready8", int'(rdy8), 1);
        chk("rst_out_valid8", int'(ov8), 0);
        chk("rst_res8", int'(res8), 0);
        chk("rst_p_out8", int'(po8), 0);
        chk("rst_in_ready16", int'(rdy16), 1);
        chk("rst_res16", int'(res16), 0);
        chk("rst_p_out16", int'(po16), 0);
        rdy_at8  = cyc;
        rdy_at16 = cyc;

        // Reset during a decimal op, and reset coinciding with an accept.
        v8 = 1'b1; op8 = 4'h3; a8 = 8'h19; b8 = 8'h28; p8 = 8'h08;
        chk("dec_accept_ready8", int'(rdy8), 1);
        @(posedge clk);
        #1 v8 = 1'b0;
        @(negedge clk);
        chk("dec_busy_ready8", int'(rdy8), 0);
        rst_n = 1'b0;
        v16 = 1'b1; op16 = 4'h5; a16 = 16'h0; b16 = 16'h1234; p16 = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_out_valid8", int'(ov8), 0);
            chk("mid_rst_out_valid16", int'(ov16), 0);
            chk("mid_rst_in_ready8", int'(rdy8), 1);
            chk("mid_rst_res8", int'(res8), 0);
            chk("mid_rst_p_out8", int'(po8), 0);
            chk("mid_rst_res16", int'(res16), 0);
        end
        rdy_at8  = cyc;
        rdy_at16 = cyc;

        // Directed cases
        send(0, 3, 'h50, 'h50, 8'h00);
        send(0, 3, 'h19, 'h28, 8'h08);
        send(0, 7, 'h10, 'h01, 8'h09);
        send(0, 7, 'h00, 'h01, 8'h09);
        send(0, 5, 'h00, 'h00, 8'h00);
        send(0, 6, 'h40, 'h41, 8'h00);
        send(0, 11, 'h00, 'h01, 8'h01);
        send(0, 12, 'h0F, 'hC0, 8'h00);
        send(1, 3, 'h9999, 'h0001, 8'h08);
        send(1, 12, 'h000F, 'hC000, 8'h00);
        send(1, 7, 'h0000, 'h0001, 8'h09);
        send(0, 13, 'h00, 'hFF, 8'h41);
        send(0, 14, 'h00, 'h00, 8'h00);

        // Randomized traffic over both widths
        for (int i = 0; i < 300; i++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            send(wide, int'($urandom_range(0, 15)),
                 int'($urandom & (wide ? 32'hFFFF : 32'hFF)),
                 int'($urandom & (wide ? 32'hFFFF : 32'hFF)),
                 8'($urandom));
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end

        n = 0;
        while ((q8.size() + q16.size()) > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if ((q8.size() + q16.size()) > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", q8.size() + q16.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
